sec_err_monitor: RTL
====================

SEC_ERR_MONITOR -- requirements
Module: sec_err_monitor

Interface
REQ-001 SHALL have parameter ESC_THRESHOLD, default 4, the number of minor events within one window that escalates to major.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 1024, the escalation window length in clk cycles.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port pc_err_i  input  1  PC hardening error, major.
REQ-006 SHALL have port csr_err_i  input  1  CSR shadow mismatch, major.
REQ-007 SHALL have port itf_int_err_i  input  1  bus interface integrity error, major.
REQ-008 SHALL have port lfsr_lockup_i  input  1  dummy/hint LFSR lockup, minor, level.
REQ-009 SHALL have port clr_i  input  1  one-cycle request to clear sticky status.
REQ-010 SHALL have port alert_major_o  output  1  major alert to the top level.
REQ-011 SHALL have port alert_minor_o  output  1  minor alert to the top level.
REQ-012 SHALL have port err_status_o  output  4  sticky cause bits {lfsr, itf, csr, pc}.
REQ-013 SHALL have port state_o  output  2  current sec_state_e.

Function
REQ-014 SHALL register alert_major_o as the OR of the three major inputs, giving 1-cycle latency, level behaviour and no edge detection.
REQ-015 SHALL additionally assert alert_major_o for exactly one cycle on the cycle after an escalation.
REQ-016 SHALL define a minor event as a rising edge of lfsr_lockup_i, detected against a registered copy of the input.
REQ-017 SHALL register alert_minor_o as a one-cycle pulse on the cycle after each minor event.
REQ-018 SHALL set each err_status_o bit the cycle after its source is high.
- clr_i clears all bits.
- A set and a clear in the same cycle: set wins.
- In state MAJOR, clr_i has no effect.
REQ-019 SHALL implement an FSM with states OK, MINOR and MAJOR.
- OK -> MINOR on a minor event.
- Any state -> MAJOR on a major input or on escalation.
- MINOR -> OK on clr_i with no minor event in the same cycle.
- MAJOR is terminal until rst_n.
REQ-020 SHALL implement the escalation counter as follows.
- The window timer starts on the first minor event while the timer is idle.
- Each minor event increments esc_cnt, saturating at ESC_THRESHOLD.
- When esc_cnt reaches ESC_THRESHOLD with the timer at or below WINDOW_CYCLES-1, escalation fires.
- When the timer reaches WINDOW_CYCLES-1 without escalation, timer and esc_cnt clear the next cycle.
REQ-021 SHALL resolve a minor event that coincides with window expiry by counting it as the first event of a new window (esc_cnt=1, timer restarted at 0).
REQ-022 SHALL freeze the timer and esc_cnt once in MAJOR.
REQ-023 SHALL size the timer as $clog2(WINDOW_CYCLES) bits and esc_cnt as $clog2(ESC_THRESHOLD+1) bits, with no wrap-around.

Reset
REQ-024 SHALL on rst_n low, asynchronously: alert_major_o=0, alert_minor_o=0, err_status_o=4'b0, state_o=OK, timer=0, esc_cnt=0, and registered lfsr_lockup=0.
REQ-025 SHALL treat lfsr_lockup_i already high at reset release as a minor event on the first clock edge.

Configuration
REQ-026 SHALL, when macro SEC_ERR_ESCALATION_EN is defined, include the window timer, esc_cnt and escalation per REQ-015/020/021.
REQ-027 SHALL, when SEC_ERR_ESCALATION_EN is undefined, omit timer and counter logic; minor events then never reach MAJOR, and all other behaviour is unchanged.

Structure
REQ-028 SHALL place the sec_state_e enum (OK=2'b00, MINOR=2'b01, MAJOR=2'b10) and the cause bit index constants in the shared core package.
REQ-029 SHALL place the window timer and escalation counter in one sub-module, sec_esc_counter, which is instantiated only under SEC_ERR_ESCALATION_EN.

Verification
REQ-030 SHALL verify: pc_err_i high for 1 cycle -> alert_major_o high 1 cycle later for 1 cycle, err_status_o=4'b0001, state_o=MAJOR; clr_i afterwards leaves status unchanged.
REQ-031 SHALL verify: lfsr_lockup_i held high 10 cycles -> exactly one alert_minor_o pulse, state_o=MINOR, err_status_o=4'b1000; clr_i -> state_o=OK and err_status_o=0.
REQ-032 SHALL verify: 4 lfsr_lockup_i pulses within 100 cycles with defaults -> one-cycle alert_major_o pulse after the 4th event, state_o=MAJOR.
REQ-033 SHALL verify: 3 pulses, then 1100 idle cycles, then 1 pulse -> no major alert, and esc_cnt=1 after the last pulse.
REQ-034 SHALL verify: clr_i coincident with csr_err_i in OK -> err_status_o=4'b0010 and state_o=MAJOR.
REQ-035 SHALL verify: rst_n asserted mid-window with esc_cnt=3 -> all outputs zero immediately, without waiting for a clock edge, and the next pulse gives esc_cnt=1.

Source files
------------

// File: rtl/sec_err_monitor_pkg.sv
// Shared types and constants for the security error monitor.
package sec_err_monitor_pkg;

    typedef enum logic [1:0] {
        OK    = 2'b00,
        MINOR = 2'b01,
        MAJOR = 2'b10
    } sec_state_e;

    localparam int unsigned NUM_CAUSES = 4;

    // Bit positions inside err_status_o
    localparam int unsigned CAUSE_PC   = 0;
    localparam int unsigned CAUSE_CSR  = 1;
    localparam int unsigned CAUSE_ITF  = 2;
    localparam int unsigned CAUSE_LFSR = 3;

endpackage

// File: rtl/sec_esc_counter.sv
// Escalation window: counts minor events inside a WINDOW_CYCLES window and
// flags escalation combinationally on the event that reaches ESC_THRESHOLD.
module sec_esc_counter
    import sec_err_monitor_pkg::*;
#(
    parameter int unsigned ESC_THRESHOLD = 4,
    parameter int unsigned WINDOW_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic minor_evt_i,
    input  logic freeze_i,
    output logic esc_fire_c_o
);

    localparam int unsigned TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned CW = $clog2(ESC_THRESHOLD + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(ESC_THRESHOLD);

    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] esc_cnt_q, esc_cnt_d;
    logic          active_q, active_d;
    logic          expire_c;
    logic          new_window_c;
    logic [CW-1:0] cnt_evt_c;

    // Next-state of the window; an event on the expiry cycle opens a new window
    always_comb begin
        timer_d      = timer_q;
        esc_cnt_d    = esc_cnt_q;
        active_d     = active_q;
        expire_c     = active_q && (timer_q == TIMER_LAST);
        new_window_c = !active_q || expire_c;

        if (new_window_c) begin
            cnt_evt_c = CW'(1);
        end else if (esc_cnt_q == CNT_MAX) begin
            cnt_evt_c = CNT_MAX;
        end else begin
            cnt_evt_c = CW'(esc_cnt_q + CW'(1));
        end

        if (!freeze_i) begin
            if (expire_c) begin
                timer_d   = '0;
                esc_cnt_d = '0;
                active_d  = 1'b0;
            end else if (active_q) begin
                timer_d = TW'(timer_q + TW'(1));
            end

            if (minor_evt_i) begin
                esc_cnt_d = cnt_evt_c;
                if (new_window_c) begin
                    active_d = 1'b1;
                    timer_d  = '0;
                end
            end
        end

        esc_fire_c_o = minor_evt_i && !freeze_i && (cnt_evt_c == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            esc_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            esc_cnt_q <= esc_cnt_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/sec_err_monitor.sv
// Security error monitor: registered major/minor alerts, sticky cause bits and
// OK/MINOR/MAJOR state. Define SEC_ERR_ESCALATION_EN for minor->major escalation.
module sec_err_monitor
    import sec_err_monitor_pkg::*;
#(
    parameter int unsigned ESC_THRESHOLD = 4,
    parameter int unsigned WINDOW_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_err_i,
    input  logic                  csr_err_i,
    input  logic                  itf_int_err_i,
    input  logic                  lfsr_lockup_i,
    input  logic                  clr_i,
    output logic                  alert_major_o,
    output logic                  alert_minor_o,
    output logic [NUM_CAUSES-1:0] err_status_o,
    output logic [1:0]            state_o
);

    if (ESC_THRESHOLD < 1 || WINDOW_CYCLES < 2) begin : g_cfg_err
        $error("sec_err_monitor: ESC_THRESHOLD must be >= 1 and WINDOW_CYCLES >= 2");
    end

    sec_state_e            state_q, state_d;
    logic                  lfsr_q;
    logic                  alert_major_q, alert_major_d;
    logic                  alert_minor_q, alert_minor_d;
    logic [NUM_CAUSES-1:0] err_status_q, err_status_d;
    logic [NUM_CAUSES-1:0] set_c;
    logic                  minor_evt_c;
    logic                  major_in_c;
    logic                  in_major_c;
    logic                  esc_fire_c;

    assign minor_evt_c = lfsr_lockup_i && !lfsr_q;
    assign major_in_c  = pc_err_i || csr_err_i || itf_int_err_i;
    assign in_major_c  = (state_q == MAJOR);

`ifdef SEC_ERR_ESCALATION_EN
    sec_esc_counter #(
        .ESC_THRESHOLD (ESC_THRESHOLD),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_esc (
        .clk          (clk),
        .rst_n        (rst_n),
        .minor_evt_i  (minor_evt_c),
        .freeze_i     (in_major_c),
        .esc_fire_c_o (esc_fire_c)
    );
`else
    assign esc_fire_c = 1'b0;
`endif

    // Next-state, sticky status and alert computation
    always_comb begin
        state_d       = state_q;
        alert_major_d = major_in_c || esc_fire_c;
        alert_minor_d = minor_evt_c;

        set_c             = '0;
        set_c[CAUSE_PC]   = pc_err_i;
        set_c[CAUSE_CSR]  = csr_err_i;
        set_c[CAUSE_ITF]  = itf_int_err_i;
        set_c[CAUSE_LFSR] = lfsr_lockup_i;

        // Clear is ignored in MAJOR; a same-cycle set overrides the clear
        if (clr_i && !in_major_c) begin
            err_status_d = set_c;
        end else begin
            err_status_d = err_status_q | set_c;
        end

        if (major_in_c || esc_fire_c) begin
            state_d = MAJOR;
        end else begin
            unique case (state_q)
                OK:      if (minor_evt_c) state_d = MINOR;
                MINOR:   if (clr_i && !minor_evt_c) state_d = OK;
                MAJOR:   state_d = MAJOR;
                default: state_d = MAJOR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= OK;
            lfsr_q        <= 1'b0;
            alert_major_q <= 1'b0;
            alert_minor_q <= 1'b0;
            err_status_q  <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_lockup_i;
            alert_major_q <= alert_major_d;
            alert_minor_q <= alert_minor_d;
            err_status_q  <= err_status_d;
        end
    end

    assign alert_major_o = alert_major_q;
    assign alert_minor_o = alert_minor_q;
    assign err_status_o  = err_status_q;
    assign state_o       = state_q;

endmodule
